// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared loader state encoding and instruction word width
package riscv_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } loader_state_e;

endpackage

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - serialises multi-word load beats into instruction-memory writes
// Optional running checksum of written words is built when INST_LOADER_CHECKSUM_EN is defined.
module inst_mem_loader
    import riscv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 9,
    parameter int LANES  = 2,
    parameter int DEPTH  = 128,
    localparam int MEM_AW = $clog2(DEPTH),
    localparam int CNT_W  = MEM_AW + 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load_valid,
    output logic                    o_load_ready,
    input  logic [ADDR_W-1:0]       i_load_addr,
    input  logic [LANES*DATA_W-1:0] i_load_data,
    input  logic                    i_load_last,
    output logic                    o_mem_we,
    output logic [MEM_AW-1:0]       o_mem_waddr,
    output logic [DATA_W-1:0]       o_mem_wdata,
    output logic                    o_core_reset,
    output logic                    o_load_err,
    output logic [CNT_W-1:0]        o_words_written,
    output logic [DATA_W-1:0]       o_checksum
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    loader_state_e           r_state;
    loader_state_e           w_state_nxt;
    logic [LW-1:0]           r_lane;
    logic [LW-1:0]           w_lane_nxt;
    logic [LANES*DATA_W-1:0] r_data;
    logic [ADDR_W-3:0]       r_base;
    logic                    r_last;

    logic                    w_accept;
    logic                    w_aligned;
    logic                    w_start;
    logic                    w_lane_end;
    logic [DATA_W-1:0]       w_lane_word;
    logic [MEM_AW-1:0]       w_waddr;

    logic                    r_mem_we;
    logic [MEM_AW-1:0]       r_mem_waddr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic                    r_core_reset;
    logic                    r_load_err;
    logic [CNT_W-1:0]        r_words;

    assign o_load_ready = (r_state != WRITE);
    assign w_accept     = i_load_valid && o_load_ready;
    assign w_aligned    = (i_load_addr[1:0] == 2'b00);
    assign w_start      = w_accept && w_aligned;
    assign w_lane_end   = (r_lane == LW'(LANES - 1));
    assign w_lane_word  = r_data[r_lane*DATA_W +: DATA_W];
    // Truncating both operands first gives the modulo-DEPTH wrap for free.
    assign w_waddr      = MEM_AW'(r_base) + MEM_AW'(r_lane);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        case (r_state)
            IDLE, DONE: begin
                if (w_start) begin
                    w_state_nxt = WRITE;
                    w_lane_nxt  = '0;
                end
            end
            WRITE: begin
                if (w_lane_end) begin
                    w_state_nxt = r_last ? DONE : IDLE;
                end else begin
                    w_lane_nxt = r_lane + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_lane_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data <= '0;
            r_base <= '0;
            r_last <= 1'b0;
        end else if (w_start) begin
            r_data <= i_load_data;
            r_base <= i_load_addr[ADDR_W-1:2];
            r_last <= i_load_last;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mem_we     <= 1'b0;
            r_mem_waddr  <= '0;
            r_mem_wdata  <= '0;
            r_core_reset <= 1'b1;
            r_load_err   <= 1'b0;
            r_words      <= '0;
        end else begin
            r_mem_we <= (r_state == WRITE);
            if (r_state == WRITE) begin
                r_mem_waddr <= w_waddr;
                r_mem_wdata <= w_lane_word;
                if (r_words != '1) begin
                    r_words <= r_words + 1'b1;
                end
            end
            if (w_accept && !w_aligned) begin
                r_load_err <= 1'b1;
            end
            // Released one edge after DONE is reached; a reload beat re-arms it at acceptance.
            r_core_reset <= !((r_state == DONE) && !w_start);
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_checksum <= '0;
        end else if (r_state == WRITE) begin
            r_checksum <= r_checksum + w_lane_word;
        end
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = '0;
`endif

    assign o_mem_we        = r_mem_we;
    assign o_mem_waddr     = r_mem_waddr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_core_reset    = r_core_reset;
    assign o_load_err      = r_load_err;
    assign o_words_written = r_words;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - randomized and directed bench for inst_mem_loader against a queue model
module tb_inst_mem_loader;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int LANES   = 2;
    localparam int DEPTH   = 128;
    localparam int MEM_AW  = $clog2(DEPTH);
    localparam int CNT_W   = MEM_AW + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    i_clk = 1'b0;
    logic                    i_reset = 1'b1;
    logic                    i_load_valid = 1'b0;
    logic                    o_load_ready;
    logic [ADDR_W-1:0]       i_load_addr = '0;
    logic [LANES*DATA_W-1:0] i_load_data = '0;
    logic                    i_load_last = 1'b0;
    logic                    o_mem_we;
    logic [MEM_AW-1:0]       o_mem_waddr;
    logic [DATA_W-1:0]       o_mem_wdata;
    logic                    o_core_reset;
    logic                    o_load_err;
    logic [CNT_W-1:0]        o_words_written;
    logic [DATA_W-1:0]       o_checksum;

    inst_mem_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .DEPTH(DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_load_valid    (i_load_valid),
        .o_load_ready    (o_load_ready),
        .i_load_addr     (i_load_addr),
        .i_load_data     (i_load_data),
        .i_load_last     (i_load_last),
        .o_mem_we        (o_mem_we),
        .o_mem_waddr     (o_mem_waddr),
        .o_mem_wdata     (o_mem_wdata),
        .o_core_reset    (o_core_reset),
        .o_load_err      (o_load_err),
        .o_words_written (o_words_written),
        .o_checksum      (o_checksum)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          ends_prog;
    } wr_t;

    wr_t         q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_data;
    bit          m_core_reset;
    bit          m_fall_pending;
    bit          m_err;
    int          m_words;
    logic [31:0] m_sum;

    int          log_a[$];
    logic [31:0] log_d[$];
    int          t_w7;
    int          t_fall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 0;
        m_addr = 0;
        m_data = '0;
        m_core_reset = 1;
        m_fall_pending = 0;
        m_err = 0;
        m_words = 0;
        m_sum = '0;
    endtask

    always @(posedge i_reset) model_reset();

    // Transaction-level model: an accepted beat queues its lanes, one lane emerges per edge.
    always @(posedge i_clk) begin
        bit   acc;
        bit   aligned;
        wr_t  e;
        cyc++;
        if (!i_reset) begin
            acc = i_load_valid && (q.size() == 0);
            aligned = (i_load_addr[1:0] == 2'b00);
            m_we = 0;
            if (m_fall_pending) begin
                m_core_reset = 0;
                m_fall_pending = 0;
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                m_we = 1;
                m_addr = e.addr;
                m_data = e.data;
                if (m_words < CNT_MAX) m_words++;
`ifdef INST_LOADER_CHECKSUM_EN
                m_sum = m_sum + e.data;
`endif
                if (e.ends_prog) m_fall_pending = 1;
            end
            if (acc && !aligned) m_err = 1;
            if (acc && aligned) begin
                m_core_reset = 1;
                for (int i = 0; i < LANES; i++) begin
                    e.addr = ((int'(i_load_addr) >> 2) + i) % DEPTH;
                    e.data = i_load_data[i*DATA_W +: DATA_W];
                    e.ends_prog = i_load_last && (i == LANES - 1);
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge i_clk) begin
        if (!i_reset) begin
            chk("load_ready", o_load_ready, (q.size() == 0));
            chk("mem_we", o_mem_we, m_we);
            if (m_we) begin
                chk("mem_waddr", o_mem_waddr, m_addr);
                chk("mem_wdata", o_mem_wdata, m_data);
            end
            chk("core_reset", o_core_reset, m_core_reset);
            chk("load_err", o_load_err, m_err);
            chk("words_written", o_words_written, m_words);
            chk("checksum", o_checksum, m_sum);
            if (o_mem_we) begin
                log_a.push_back(int'(o_mem_waddr));
                log_d.push_back(o_mem_wdata);
                if (o_mem_waddr == 7) t_w7 = cyc;
            end
            if (!o_core_reset && t_fall < 0) t_fall = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [LANES*DATA_W-1:0] d, input logic l);
        bit ok;
        ok = 0;
        @(negedge i_clk);
        #1;
        i_load_valid = 1;
        i_load_addr = a;
        i_load_data = d;
        i_load_last = l;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (o_load_ready) ok = 1;
            @(posedge i_clk);
            #1;
        end
        i_load_valid = 0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat at %0h never accepted", a);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1;
        @(negedge i_clk);
        #1;
        i_reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        model_reset();
        t_w7 = -1;
        t_fall = -1;
        repeat (2) @(negedge i_clk);
        #1;
        i_reset = 0;
        idle(1);
        chk("rst_ready", o_load_ready, 1);
        chk("rst_we", o_mem_we, 0);
        chk("rst_core_reset", o_core_reset, 1);
        chk("rst_err", o_load_err, 0);
        chk("rst_words", o_words_written, 0);
        chk("rst_sum", o_checksum, 0);

        log_a.delete(); log_d.delete();
        send(9'h000, {32'h00400113, 32'h00100393}, 1'b0);
        idle(3);
        chk("single_cnt", log_a.size(), 2);
        chk("single_a0", log_a[0], 0);
        chk("single_d0", log_d[0], 32'h00100393);
        chk("single_a1", log_a[1], 1);
        chk("single_d1", log_d[1], 32'h00400113);
        chk("single_words", o_words_written, 2);
        chk("single_core_reset", o_core_reset, 1);

        log_a.delete(); log_d.delete();
        send(9'h002, {32'hdeadbeef, 32'hcafef00d}, 1'b1);
        idle(3);
        chk("misal_nowrite", log_a.size(), 0);
        chk("misal_err", o_load_err, 1);
        chk("misal_core_reset", o_core_reset, 1);
        send(9'h00c, {32'h22222222, 32'h11111111}, 1'b0);
        idle(3);
        chk("after_misal_a0", log_a[0], 3);
        chk("after_misal_a1", log_a[1], 4);
        chk("err_sticky", o_load_err, 1);

        log_a.delete(); log_d.delete();
        send(9'h1fc, {32'h0000bbbb, 32'h0000aaaa}, 1'b0);
        idle(3);
        chk("wrap_a0", log_a[0], 127);
        chk("wrap_a1", log_a[1], 0);

        do_reset();
        log_a.delete(); log_d.delete();
        t_w7 = -1;
        t_fall = -1;
        for (int b = 0; b < 4; b++) begin
            send(ADDR_W'(b * 8),
                 {32'h11111111 * (2 * b + 2), 32'h11111111 * (2 * b + 1)}, (b == 3));
        end
        idle(4);
        bad = 0;
        for (int i = 0; i < 8; i++) if (log_a[i] != i) bad++;
        chk("four_cnt", log_a.size(), 8);
        chk("four_addr_bad", bad, 0);
        chk("four_words", o_words_written, 8);
        chk("four_fall_delay", t_fall - t_w7, 1);
        chk("four_core_released", o_core_reset, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        chk("four_sum", o_checksum, 32'h66666664);
`else
        chk("four_sum", o_checksum, 32'h0);
`endif

        send(9'h020, {32'h00000013, 32'h00000093}, 1'b1);
        chk("reload_rise", o_core_reset, 1);
        idle(4);
        chk("reload_fall", o_core_reset, 0);

        log_a.delete(); log_d.delete();
        send(9'h040, {32'h0badf00d, 32'h00c0ffee}, 1'b0);
        @(posedge i_clk);
        #2;
        chk("mid_lane0_we", o_mem_we, 1);
        chk("mid_lane0_addr", o_mem_waddr, 16);
        i_reset = 1;
        #1;
        chk("mid_rst_we", o_mem_we, 0);
        chk("mid_rst_addr", o_mem_waddr, 0);
        chk("mid_rst_data", o_mem_wdata, 0);
        chk("mid_rst_core", o_core_reset, 1);
        chk("mid_rst_words", o_words_written, 0);
        chk("mid_rst_ready", o_load_ready, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_reset = 0;
        idle(3);
        bad = 0;
        foreach (log_a[i]) if (log_a[i] == 17) bad++;
        chk("mid_lane1_absent", bad, 0);

        for (int n = 0; n < 1500; n++) begin
            logic [ADDR_W-1:0]       a;
            logic [LANES*DATA_W-1:0] d;
            @(negedge i_clk);
            #1;
            a = ADDR_W'($urandom);
            if ($urandom_range(0, 9) < 8) a[1:0] = 2'b00;
            for (int i = 0; i < LANES; i++) d[i*DATA_W +: DATA_W] = $urandom;
            i_load_valid = ($urandom_range(0, 9) < 6);
            i_load_addr = a;
            i_load_data = d;
            i_load_last = ($urandom_range(0, 9) == 0);
        end
        i_load_valid = 0;
        idle(5);
        chk("rand_words_saturated", o_words_written, CNT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
